// File: rtl/mem_stage.sv
// Memory-access pipeline stage between EXE and WB: lane-aligns stores, sign/zero-extends loads,
// flags illegal or misaligned accesses, and carries WB control along with each operation.
module mem_stage #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 10,
  parameter int WB_W   = 11
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_read,
  input  logic                             in_write,
  input  logic [1:0]                       in_len,
  input  logic                             in_un,
  input  logic [ADDR_W-1:0]                in_addr,
  input  logic [XLEN-1:0]                  in_data,
  input  logic [WB_W-1:0]                  in_wb,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_W-$clog2(XLEN/8)-1:0] mem_addr,
  output logic [XLEN/8-1:0]                mem_be,
  output logic [XLEN-1:0]                  mem_wdata,
  input  logic                             mem_ack,
  input  logic [XLEN-1:0]                  mem_rdata,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [XLEN-1:0]                  out_result,
  output logic [WB_W-1:0]                  out_wb,
  output logic                             out_fault
);
  localparam int OFF_W = $clog2(XLEN/8);
  localparam int NB    = XLEN/8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]              state_q, state_d;
  logic                    out_valid_q, out_valid_d;
  logic [XLEN-1:0]         out_result_q, out_result_d;
  logic [WB_W-1:0]         out_wb_q, out_wb_d;
  logic                    out_fault_q, out_fault_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_W-OFF_W-1:0] mem_addr_q, mem_addr_d;
  logic [NB-1:0]           mem_be_q, mem_be_d;
  logic [XLEN-1:0]         mem_wdata_q, mem_wdata_d;
  logic [OFF_W-1:0]        off_q, off_d;
  logic [1:0]              len_q, len_d;
  logic                    un_q, un_d;

  logic             accept, is_mem, fault;
  logic [OFF_W-1:0] in_off;
  int               sz, offi, nbits;
  logic [NB-1:0]    be_new;
  logic [XLEN-1:0]  wr_shift, wdata_new, ld_shift, ld_val;
  logic             ld_msb;

  assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign is_mem   = in_read | in_write;
  assign in_off   = in_addr[OFF_W-1:0];

  // Decode of the offered operation: fault check, lane enables, aligned store data.
  always_comb begin
    sz     = 1 << in_len;
    offi   = int'(in_off);
    fault  = (in_read & in_write) | (is_mem & (sz > NB)) | (is_mem & ((offi & (sz - 1)) != 0));
    be_new = '0;
    for (int i = 0; i < NB; i++) be_new[i] = (i >= offi) && (i < offi + sz);
    wr_shift  = in_data << {in_off, 3'b000};
    wdata_new = '0;
    for (int i = 0; i < XLEN; i++) wdata_new[i] = wr_shift[i] & be_new[i/8];
  end

  // Load extraction uses the offset/size captured at accept, not the live inputs.
  always_comb begin
    ld_shift = mem_rdata >> {off_q, 3'b000};
    nbits    = 8 << len_q;
    case (len_q)
      2'd0:    ld_msb = ld_shift[7];
      2'd1:    ld_msb = ld_shift[15];
      2'd2:    ld_msb = ld_shift[31];
      default: ld_msb = ld_shift[XLEN-1];
    endcase
    ld_val = '0;
    for (int i = 0; i < XLEN; i++) ld_val[i] = (i < nbits) ? ld_shift[i] : (~un_q & ld_msb);
  end

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_wb_d     = out_wb_q;
    out_fault_d  = out_fault_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    off_d        = off_q;
    len_d        = len_q;
    un_d         = un_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          out_wb_d     = in_wb;
          out_result_d = in_data;
          out_fault_d  = fault;
          if (fault || !is_mem) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
          end else begin
            state_d     = S_WAIT;
            out_valid_d = 1'b0;
            mem_req_d   = 1'b1;
            mem_we_d    = in_write;
            mem_addr_d  = in_addr[ADDR_W-1:OFF_W];
            mem_be_d    = be_new;
            mem_wdata_d = wdata_new;
            off_d       = in_off;
            len_d       = in_len;
            un_d        = in_un;
          end
        end else if (state_q == S_DONE && out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          if (!mem_we_q) out_result_d = ld_val;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_wb_q     <= '0;
      out_fault_q  <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      off_q        <= '0;
      len_q        <= '0;
      un_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_wb_q     <= out_wb_d;
      out_fault_q  <= out_fault_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      off_q        <= off_d;
      len_q        <= len_d;
      un_q         <= un_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_wb     = out_wb_q;
  assign out_fault  = out_fault_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Parametrised, handshaked memory-access pipeline stage for the simple CPU. It sits between EXE and WB. It accepts one operation at a time from EXE and generates the word address, byte enables and lane-aligned store data. It talks to data memory through a request/acknowledge handshake with variable latency, then extracts and sign/zero-extends load data. Misaligned accesses are flagged instead of being silently corrupted. WB passthrough bits travel with the operation.

## Interface
Parameters:
- XLEN, 32, datapath width; 32 or 64.
- ADDR_W, 10, byte-address width.
- WB_W, 11, width of the writeback passthrough field.
- OFF_W (localparam), log2(XLEN/8).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  EXE offers an operation.
- in_ready  out  1  stage accepts; transfer when in_valid & in_ready.
- in_read  in  1  load.
- in_write  in  1  store.
- in_len  in  2  access size = 2^in_len bytes (00 byte, 01 half, 10 word, 11 dword).
- in_un  in  1  zero-extend load when 1, sign-extend when 0.
- in_addr  in  ADDR_W  byte address.
- in_data  in  XLEN  EXE result / store value.
- in_wb  in  WB_W  writeback control passthrough.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  request is a write.
- mem_addr  out  ADDR_W-OFF_W  word address = in_addr[ADDR_W-1:OFF_W].
- mem_be  out  XLEN/8  byte enables, bit i = byte lane i (bits 8i+7:8i).
- mem_wdata  out  XLEN  lane-aligned store data.
- mem_ack  in  1  memory completes request; mem_rdata valid this cycle for reads.
- mem_rdata  in  XLEN  read data.
- out_valid  out  1  result available to WB.
- out_ready  in  1  WB consumes.
- out_result  out  XLEN  load data or passthrough in_data.
- out_wb  out  WB_W  latched in_wb.
- out_fault  out  1  operation was illegal; no memory side effect.

## Operation
- FSM states IDLE, WAIT, DONE. Reset → IDLE. All registered outputs reset to 0: out_valid, out_result, out_wb, out_fault, mem_req, mem_we, mem_be, mem_addr, mem_wdata.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- On accept, let size = 2^in_len and off = in_addr[OFF_W-1:0].
- Fault is raised if any of the following holds:
  - in_read & in_write;
  - (in_read|in_write) & size > XLEN/8;
  - (in_read|in_write) & (off & (size-1)) != 0.
- Fault or non-memory op: go to DONE next cycle with out_result = in_data and out_fault = fault. mem_req is never raised.
- Legal load/store: go to WAIT. Registered outputs become:
  - mem_req = 1; mem_we = in_write;
  - mem_be = ((1<<size)-1) << off;
  - mem_wdata = in_data << (8*off), with bits outside the enabled lanes = 0.
- WAIT: mem_req and all mem_* outputs stay stable until the cycle mem_ack=1. On that edge, mem_req←0 and state→DONE.
  - Load: out_result = (mem_rdata >> 8*off) truncated to size bytes, extended with ~in_un & MSB. When size = XLEN/8 the value passes unmodified.
  - Store: out_result = in_data.
- DONE: out_valid = 1 and all outputs stay stable until out_ready. If out_ready & in_valid, the next op is accepted the same edge (the DONE→DONE/WAIT transition follows the rules above). If out_ready & !in_valid, go to IDLE and out_valid←0.
- mem_ack is ignored in IDLE and DONE.
- in_len is 11 with XLEN=32 on a memory op: fault.

## Timing
- Non-memory/fault op: accepted at edge N, out_valid at N+1. Back-to-back throughput is 1/cycle with out_ready held high.
- Memory op: accepted at edge N, mem_req high from N+1. With ack in the first request cycle, out_valid is high from N+2. Each additional ack-wait cycle adds 1.
- Reset asserted mid-WAIT: mem_req = 0 and state = IDLE from the next edge. A late mem_ack after reset is ignored. Reset wins over every simultaneous event.
- No combinational path from mem_ack/mem_rdata to any output. in_ready depends combinationally on out_ready only.

## Test plan
- XLEN=32 lb, addr 0x0B, un=0, mem_rdata 0x80FF1234 → mem_addr 0x2, mem_be 1000, out_result 0xFFFFFF80. Repeat with un=1 → 0x00000080.
- sh, addr 0x06, in_data 0x0000ABCD → mem_we 1, mem_be 1100, mem_wdata 0xABCD0000, out_result 0x0000ABCD.
- lw, addr 0x02 → mem_req never rises, out_fault 1, out_valid one cycle after accept. in_read=in_write=1 also faults.
- lw with mem_ack delayed 3 cycles, then out_ready low 2 cycles → mem_* held stable 3 cycles, out_valid/out_result held 2 cycles, in_ready 0 until consumed.
- Five consecutive ALU ops (read=write=0), out_ready=1 → five results on consecutive cycles with matching out_wb.
- rst pulsed during WAIT, then mem_ack → mem_req 0 after reset edge, out_valid stays 0. XLEN=64 ld, addr 0x08, rdata 0x8000000000000001 → out_result unchanged.
